mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIM, default 4, max consecutive data grants while a fetch waits.
REQ-002 Parameter: MAX_WAIT, default 15, cycles of mem_en without mem_ready before timeout abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetched word, valid while if_ack high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request, held high until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data, valid while d_ack high; 0 for stores.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 err  output  1  high with the ack of a timed-out access only.
REQ-016 mem_en  output  1  memory access strobe, held until mem_ready or timeout.
REQ-017 mem_we  output  1  memory write enable, valid while mem_en.
REQ-018 mem_addr  output  32  memory address, valid while mem_en.
REQ-019 mem_wdata  output  32  memory write data, valid while mem_en.
REQ-020 mem_rdata  input  32  memory read data, valid when mem_ready.
REQ-021 mem_ready  input  1  memory completion, sampled only while mem_en.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D; all outputs registered.
REQ-023 IDLE, d_req and (not if_req or starve_cnt < STARVE_LIM) -> BUSY_D; else if_req -> BUSY_I; else stay.
REQ-024 starve_cnt: +1 per data grant issued while if_req high; cleared on every fetch grant and whenever if_req low in IDLE; saturates at STARVE_LIM.
REQ-025 On grant, address, we (0 for fetch) and wdata latched into mem_* registers; mem_en high from the cycle after the grant decision.
REQ-026 Requester inputs after grant are ignored until ack.
REQ-027 mem_ready sampled high in BUSY state at cycle M -> cycle M+1: matching ack = 1 for one cycle, rdata = mem_rdata captured at M (d_rdata = 0 if store), mem_en = 0, state IDLE.
REQ-028 Minimum latency: req sampled in IDLE at cycle N, mem_ready at N+1 -> ack at N+2.
REQ-029 In the ack cycle the acked port's req is masked from arbitration; the other port may be granted that cycle (next mem_en at M+2).
REQ-030 Wait counter clears on grant, +1 per BUSY cycle without mem_ready; reaching MAX_WAIT -> next cycle ack = 1, err = 1, rdata = 0, mem_en = 0, IDLE.
REQ-031 mem_ready in the same cycle the wait counter reaches MAX_WAIT -> normal completion, err = 0.
REQ-032 mem_ready while mem_en low is ignored.
REQ-033 if_ack and d_ack never high in the same cycle; at most one mem_en access outstanding.

Reset
REQ-034 rst high at a rising edge -> state IDLE, starve_cnt = 0, wait counter = 0, all outputs 0 the following cycle.
REQ-035 rst mid-access abandons it with no ack; a mem_ready arriving after reset is ignored.

Verification
REQ-036 if_req, if_addr=0x40, mem_ready one cycle after mem_en, mem_rdata=0x1234ABCD -> mem_addr=0x40, mem_we=0, if_ack at N+2 with if_rdata=0x1234ABCD, err=0.
REQ-037 if_req and d_req (store 0x100, 0xDEADBEEF) same cycle -> data granted first, mem_we=1, mem_wdata=0xDEADBEEF, d_ack, d_rdata=0; fetch granted in the d_ack cycle.
REQ-038 if_req held, d_req re-raised immediately after each d_ack -> exactly 4 data grants, then one fetch grant, then starve_cnt=0.
REQ-039 d_req load, mem_ready never asserted -> mem_en high for 15 cycles, then d_ack=1, err=1, d_rdata=0, mem_en=0.
REQ-040 mem_ready asserted on the 15th wait cycle -> normal ack, err=0.
REQ-041 rst during BUSY_D with mem_en high -> all outputs 0 next cycle, no d_ack, late mem_ready ignored, new if_req served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The arbiter connects through the slave modport; the environment
// (fetch unit, data unit and memory) connects through the master modport.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one
// memory port. Data wins ties unless fetch has been passed over STARVE_LIM
// times in a row. A single access is outstanding at a time; an access that
// sees no mem_ready for MAX_WAIT cycles is aborted with err. All outputs are
// registered.
module mem_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int MAX_WAIT   = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIM + 2);
    localparam int WW = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;

    logic          mem_en_q, mem_en_nxt;
    logic          mem_we_q, mem_we_nxt;
    logic [31:0]   mem_addr_q, mem_addr_nxt;
    logic [31:0]   mem_wdata_q, mem_wdata_nxt;
    logic          if_ack_q, if_ack_nxt;
    logic          d_ack_q, d_ack_nxt;
    logic          err_q, err_nxt;
    logic [31:0]   if_rdata_q, if_rdata_nxt;
    logic [31:0]   d_rdata_q, d_rdata_nxt;

    logic          fetch_req;
    logic          data_req;

    // Arbitration, access tracking and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        wait_nxt      = wait_cnt;
        mem_en_nxt    = mem_en_q;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        if_ack_nxt    = 1'b0;
        d_ack_nxt     = 1'b0;
        err_nxt       = 1'b0;
        if_rdata_nxt  = '0;
        d_rdata_nxt   = '0;

        // A requester still shows req during its own ack cycle; that request
        // has just been served, so it must not win arbitration again.
        fetch_req = bus.if_req & ~if_ack_q;
        data_req  = bus.d_req  & ~d_ack_q;

        case (state)
            IDLE: begin
                if (data_req && (!fetch_req || starve_cnt < SW'(STARVE_LIM))) begin
                    state_nxt     = BUSY_D;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = bus.d_we;
                    mem_addr_nxt  = bus.d_addr;
                    mem_wdata_nxt = bus.d_wdata;
                    wait_nxt      = '0;
                    if (fetch_req && starve_cnt < SW'(STARVE_LIM)) begin
                        starve_nxt = starve_cnt + 1'b1;
                    end
                end else if (fetch_req) begin
                    state_nxt     = BUSY_I;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = bus.if_addr;
                    mem_wdata_nxt = '0;
                    wait_nxt      = '0;
                    starve_nxt    = '0;
                end
                if (!fetch_req) begin
                    starve_nxt = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_nxt  = IDLE;
                    mem_en_nxt = 1'b0;
                    if (state == BUSY_I) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = bus.mem_rdata;
                    end else begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = mem_we_q ? 32'h0 : bus.mem_rdata;
                    end
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                    // This cycle brings the count to MAX_WAIT: abort.
                    if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                        state_nxt  = IDLE;
                        mem_en_nxt = 1'b0;
                        err_nxt    = 1'b1;
                        if (state == BUSY_I) begin
                            if_ack_nxt = 1'b1;
                        end else begin
                            d_ack_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and the starvation / wait counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
        end
    end

    // Output registers; reset clears everything so an abandoned access leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            if_ack_q    <= if_ack_nxt;
            d_ack_q     <= d_ack_nxt;
            err_q       <= err_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written timeout
// sequences, then randomized traffic checked against a transaction model.
module tb_mem_arbiter;

    localparam int STARVE_LIM = 4;
    localparam int MAX_WAIT   = 15;

    typedef struct packed {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        if_ack;
        logic        d_ack;
        logic        err;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t want;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIM(STARVE_LIM), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: which port owns the memory (0 none, 1 fetch,
    // 2 data), cycles waited, consecutive data wins over a waiting fetch.
    int   m_port;
    int   m_wait;
    int   m_starve;
    out_t m_out;

    function automatic in_t mk_in(input logic r, input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic dw, input logic [31:0] da,
                                  input logic [31:0] dd, input logic mr, input logic [31:0] md);
        return '{rst: r, if_req: ir, if_addr: ia, d_req: dr, d_we: dw, d_addr: da,
                 d_wdata: dd, mem_ready: mr, mem_rdata: md};
    endfunction

    function automatic out_t mk_out(input logic en, input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic ia, input logic da,
                                    input logic e, input logic [31:0] ir, input logic [31:0] dr);
        return '{mem_en: en, mem_we: we, mem_addr: a, mem_wdata: wd, if_ack: ia,
                 d_ack: da, err: e, if_rdata: ir, d_rdata: dr};
    endfunction

    function automatic out_t sample();
        return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ack,
                bus.d_ack, bus.err, bus.if_rdata, bus.d_rdata};
    endfunction

    task automatic drive(input in_t s);
        rst           = s.rst;
        bus.if_req    = s.if_req;
        bus.if_addr   = s.if_addr;
        bus.d_req     = s.d_req;
        bus.d_we      = s.d_we;
        bus.d_addr    = s.d_addr;
        bus.d_wdata   = s.d_wdata;
        bus.mem_ready = s.mem_ready;
        bus.mem_rdata = s.mem_rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Predict the outputs after the next edge from the transaction state.
    task automatic model_step(input in_t s);
        out_t o;
        logic f;
        logic d;
        o          = m_out;
        o.if_ack   = 1'b0;
        o.d_ack    = 1'b0;
        o.err      = 1'b0;
        o.if_rdata = '0;
        o.d_rdata  = '0;
        if (s.rst) begin
            o        = '0;
            m_port   = 0;
            m_wait   = 0;
            m_starve = 0;
        end else if (m_port != 0) begin
            if (s.mem_ready || m_wait + 1 >= MAX_WAIT) begin
                if (m_port == 1) begin
                    o.if_ack   = 1'b1;
                    o.if_rdata = s.mem_ready ? s.mem_rdata : 32'h0;
                end else begin
                    o.d_ack   = 1'b1;
                    o.d_rdata = (s.mem_ready && !o.mem_we) ? s.mem_rdata : 32'h0;
                end
                o.err    = !s.mem_ready;
                o.mem_en = 1'b0;
                m_port   = 0;
            end else begin
                m_wait++;
            end
        end else begin
            f = s.if_req && !m_out.if_ack;
            d = s.d_req && !m_out.d_ack;
            if (d && (!f || m_starve < STARVE_LIM)) begin
                m_port      = 2;
                m_wait      = 0;
                o.mem_en    = 1'b1;
                o.mem_we    = s.d_we;
                o.mem_addr  = s.d_addr;
                o.mem_wdata = s.d_wdata;
                if (f) m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
            end else if (f) begin
                m_port      = 1;
                m_wait      = 0;
                o.mem_en    = 1'b1;
                o.mem_we    = 1'b0;
                o.mem_addr  = s.if_addr;
                o.mem_wdata = 32'h0;
                m_starve    = 0;
            end
            if (!f) m_starve = 0;
        end
        m_out = o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        in_t  cur;
        out_t got;
        int   cnt;

        n_vec = 0;
        n_err = 0;
        drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Fetch at minimum latency, ack-cycle masking, idle mem_ready ignored.
        vecs.push_back('{mk_in(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0),
                         mk_out(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0),
                         mk_out(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h1234ABCD),
                         mk_out(0, 0, 32'h40, 32'h0, 1, 0, 0, 32'h1234ABCD, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0),
                         mk_out(0, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h99),
                         mk_out(0, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        // Simultaneous requests: store first, fetch granted in the d_ack cycle.
        vecs.push_back('{mk_in(0, 1, 32'h80, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0),
                         mk_out(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h80, 1, 1, 32'h100, 32'hDEADBEEF, 1, 32'h55555555),
                         mk_out(0, 1, 32'h100, 32'hDEADBEEF, 0, 1, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h80, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0),
                         mk_out(1, 0, 32'h80, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 1, 32'hCAFEF00D),
                         mk_out(0, 0, 32'h80, 32'h0, 1, 0, 0, 32'hCAFEF00D, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 0, 32'h0),
                         mk_out(0, 0, 32'h80, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        // Data load returns read data.
        vecs.push_back('{mk_in(0, 0, 32'h0, 1, 0, 32'h104, 32'h0, 0, 32'h0),
                         mk_out(1, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 0, 32'h0, 1, 0, 32'h104, 32'h0, 1, 32'h0BADF00D),
                         mk_out(0, 0, 32'h104, 32'h0, 0, 1, 0, 32'h0, 32'h0BADF00D)});
        vecs.push_back('{mk_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0),
                         mk_out(0, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        // Reset mid-access, late mem_ready, then a normal fetch.
        vecs.push_back('{mk_in(0, 0, 32'h0, 1, 1, 32'h200, 32'h11, 0, 32'h0),
                         mk_out(1, 1, 32'h200, 32'h11, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(1, 0, 32'h0, 1, 1, 32'h200, 32'h11, 0, 32'h0),
                         mk_out(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h22),
                         mk_out(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, 0, 32'h0),
                         mk_out(1, 0, 32'h44, 32'h0, 0, 0, 0, 32'h0, 32'h0)});
        vecs.push_back('{mk_in(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, 1, 32'h77),
                         mk_out(0, 0, 32'h44, 32'h0, 1, 0, 0, 32'h77, 32'h0)});

        foreach (vecs[i]) begin
            drive(vecs[i].stim);
            tick();
            check($sformatf("vec%0d", i), sample(), vecs[i].want);
        end

        // Load with no mem_ready: 15 cycles of mem_en, then an error ack.
        drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mk_in(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, 0, 32'h0));
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_en) break;
            cnt++;
            tick();
        end
        check("timeout_len", 133'(cnt), 133'(MAX_WAIT));
        check("timeout_ack", {bus.d_ack, bus.err, bus.d_rdata, bus.mem_en, bus.if_ack},
              {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
        bus.d_req = 1'b0;
        tick();
        check("timeout_after", {bus.d_ack, bus.err, bus.mem_en}, 3'b000);

        // mem_ready on the last permitted wait cycle completes normally.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h304;
        tick();
        for (int i = 1; i < MAX_WAIT; i++) tick();
        check("late_ready_en", 133'(bus.mem_en), 133'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hA5A5_5A5A;
        tick();
        check("late_ready_ack", {bus.d_ack, bus.err, bus.d_rdata, bus.mem_en},
              {1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0});
        bus.mem_ready = 1'b0;
        bus.d_req     = 1'b0;
        tick();

        // Randomized traffic against the model.
        cur = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(cur);
        model_step(cur);
        tick();
        check("rand_reset", sample(), m_out);
        cur.rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int rdy_pct;
            rdy_pct = (c < 1500) ? 40 : 6;
            if (!cur.if_req || m_out.if_ack) begin
                cur.if_req  = ($urandom_range(0, 99) < 35);
                cur.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!cur.d_req || m_out.d_ack) begin
                cur.d_req   = ($urandom_range(0, 99) < 45);
                cur.d_we    = $urandom_range(0, 1) == 1;
                cur.d_addr  = $urandom & 32'hFFFF_FFFC;
                cur.d_wdata = $urandom;
            end
            cur.mem_ready = ($urandom_range(0, 99) < rdy_pct);
            cur.mem_rdata = $urandom;
            cur.rst       = ($urandom_range(0, 199) == 0);
            drive(cur);
            model_step(cur);
            tick();
            got = sample();
            check($sformatf("rand%0d", c), got, m_out);
            if (got.if_ack && got.d_ack) begin
                check("both_acks", 133'(1), 133'(0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
